// File: rtl/csc_pkg.sv
// Shared types and helpers for the sparse-matrix column path.
// Entry layout and round/saturate are reused by other matrix blocks.
package csc_pkg;

    localparam int unsigned CSC_MAT_RANK = 256;
    localparam int unsigned CSC_DW       = 32;
    localparam int unsigned CSC_IDX_W    = $clog2(CSC_MAT_RANK);
    localparam int unsigned CSC_PW       = 2 * CSC_DW + 2;

    typedef logic signed [CSC_PW-1:0] csc_prod_t;

    typedef struct packed {
        logic [CSC_IDX_W-1:0]     row;
        logic [CSC_IDX_W-1:0]     col;
        logic signed [CSC_DW-1:0] re;
        logic signed [CSC_DW-1:0] im;
        logic                     last;
        logic                     eof;
    } csc_entry_t;

    typedef struct packed {
        logic signed [CSC_DW-1:0] val;
        logic                     sat;
    } csc_rs_t;

    // Round half up, arithmetic shift, then clamp to a dw-bit signed range.
    function automatic csc_rs_t round_sat(input csc_prod_t x, input int unsigned shift,
                                          input int unsigned dw);
        csc_prod_t r;
        csc_prod_t hi;
        csc_prod_t lo;
        csc_rs_t   res;
        r = x;
        if (shift > 0) begin
            r = r + (csc_prod_t'(1) <<< (shift - 1));
        end
        r  = r >>> shift;
        hi = (csc_prod_t'(1) <<< (dw - 1)) - csc_prod_t'(1);
        lo = -(csc_prod_t'(1) <<< (dw - 1));
        res.sat = 1'b1;
        if (r > hi) begin
            res.val = hi[CSC_DW-1:0];
        end else if (r < lo) begin
            res.val = lo[CSC_DW-1:0];
        end else begin
            res.val = r[CSC_DW-1:0];
            res.sat = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/csc_col_gen_cmul.sv
// Two-stage complex multiplier: registered partial products, then
// combinational add, conjugate select and round/saturate.
module csc_cmul
    import csc_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned SHIFT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_vld,
    input  logic                 conj_en,
    input  logic signed [DW:0]   ar,
    input  logic signed [DW:0]   ai,
    input  logic signed [DW-1:0] sr,
    input  logic signed [DW-1:0] si,
    output logic                 out_vld,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im,
    output logic                 out_sat
);

    localparam int unsigned PPW = 2 * DW + 1;
    localparam int unsigned PW  = 2 * DW + 2;

    logic signed [PPW-1:0] rr_d, rr_q, ii_d, ii_q, ri_d, ri_q, ir_d, ir_q;
    logic                  vld_d, vld_q, conj_d, conj_q;
    logic signed [PW-1:0]  re_full, im_full;
    csc_rs_t               re_rs, im_rs;

    always_comb begin
        vld_d  = in_vld;
        conj_d = conj_en;
        rr_d   = PPW'(ar) * PPW'(sr);
        ii_d   = PPW'(ai) * PPW'(si);
        ri_d   = PPW'(ar) * PPW'(si);
        ir_d   = PPW'(ai) * PPW'(sr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            conj_q <= 1'b0;
            rr_q   <= '0;
            ii_q   <= '0;
            ri_q   <= '0;
            ir_q   <= '0;
        end else begin
            vld_q  <= vld_d;
            conj_q <= conj_d;
            rr_q   <= rr_d;
            ii_q   <= ii_d;
            ri_q   <= ri_d;
            ir_q   <= ir_d;
        end
    end

    always_comb begin
        if (conj_q) begin
            re_full = PW'(rr_q) + PW'(ii_q);
            im_full = PW'(ir_q) - PW'(ri_q);
        end else begin
            re_full = PW'(rr_q) - PW'(ii_q);
            im_full = PW'(ri_q) + PW'(ir_q);
        end
        re_rs   = round_sat(csc_prod_t'(re_full), SHIFT, DW);
        im_rs   = round_sat(csc_prod_t'(im_full), SHIFT, DW);
        out_vld = vld_q;
        out_re  = re_rs.val[DW-1:0];
        out_im  = im_rs.val[DW-1:0];
        out_sat = re_rs.sat | im_rs.sat;
    end

endmodule

// File: rtl/csc_col_gen.sv
// Column generator: per beat emits one or two CSC entries (a0*s, a1*s, or merged)
// through a credit-guarded dual-write FIFO, tracking the column within the frame.
module csc_col_gen
    import csc_pkg::*;
#(
    parameter int unsigned MAT_RANK   = 256,
    parameter int unsigned DW         = 32,
    parameter int unsigned SHIFT      = 1,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned IDX_W      = $clog2(MAT_RANK)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic                 conj_en,
    input  logic [IDX_W-1:0]     z0,
    input  logic [IDX_W-1:0]     z1,
    input  logic signed [DW-1:0] s_re,
    input  logic signed [DW-1:0] s_im,
    input  logic signed [DW-1:0] a0_re,
    input  logic signed [DW-1:0] a0_im,
    input  logic signed [DW-1:0] a1_re,
    input  logic signed [DW-1:0] a1_im,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [IDX_W-1:0]     out_row,
    output logic [IDX_W-1:0]     out_col,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im,
    output logic                 out_last,
    output logic                 out_eof,
    output logic                 sat_err
);

    localparam int unsigned AW    = DW + 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic                 conj;
        logic                 merge;
        logic [IDX_W-1:0]     z0;
        logic [IDX_W-1:0]     z1;
        logic signed [AW-1:0] a0r;
        logic signed [AW-1:0] a0i;
        logic signed [AW-1:0] a1r;
        logic signed [AW-1:0] a1i;
        logic signed [DW-1:0] sr;
        logic signed [DW-1:0] si;
    } s0_t;

    typedef struct packed {
        logic             merge;
        logic [IDX_W-1:0] z0;
        logic [IDX_W-1:0] z1;
    } s1_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(FIFO_DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    logic                 accept, pop, push, two, swap, eof_col;
    int unsigned          inflight;
    s0_t                  s0_d, s0_q;
    logic                 s0_vld_d, s0_vld_q;
    s1_t                  s1_d, s1_q;
    logic                 m0_vld, m0_sat, m1_vld, m1_sat;
    logic signed [DW-1:0] m0_re, m0_im, m1_re, m1_im;
    csc_entry_t           e_first, e_second;
    csc_entry_t           mem_d [FIFO_DEPTH];
    csc_entry_t           mem_q [FIFO_DEPTH];
    ptr_t                 wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
    cnt_t                 count_d, count_q, remain;
    logic                 out_vld_d, out_vld_q;
    csc_entry_t           out_ent_d, out_ent_q;
    logic [IDX_W-1:0]     col_d, col_q;
    logic                 sat_d, sat_q;

    // Credit reserves two FIFO slots for every beat still inside the multiplier.
    always_comb begin
        inflight = 32'(s0_vld_q) + 32'(m0_vld);
        in_rdy   = rst_n && ((32'(count_q) + 2 * inflight + 2) <= FIFO_DEPTH);
        accept   = in_vld & in_rdy;
    end

    always_comb begin
        s0_vld_d = accept;
        s0_d     = s0_q;
        if (accept) begin
            s0_d.conj  = conj_en;
            s0_d.merge = (z0 == z1);
            s0_d.z0    = z0;
            s0_d.z1    = z1;
            s0_d.a0r   = (z0 == z1) ? AW'(a0_re) + AW'(a1_re) : AW'(a0_re);
            s0_d.a0i   = (z0 == z1) ? AW'(a0_im) + AW'(a1_im) : AW'(a0_im);
            s0_d.a1r   = AW'(a1_re);
            s0_d.a1i   = AW'(a1_im);
            s0_d.sr    = s_re;
            s0_d.si    = s_im;
        end
        s1_d.merge = s0_q.merge;
        s1_d.z0    = s0_q.z0;
        s1_d.z1    = s0_q.z1;
    end

    csc_cmul #(.DW(DW), .SHIFT(SHIFT)) u_cmul0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_vld (s0_vld_q),
        .conj_en(s0_q.conj),
        .ar     (s0_q.a0r),
        .ai     (s0_q.a0i),
        .sr     (s0_q.sr),
        .si     (s0_q.si),
        .out_vld(m0_vld),
        .out_re (m0_re),
        .out_im (m0_im),
        .out_sat(m0_sat)
    );

    csc_cmul #(.DW(DW), .SHIFT(SHIFT)) u_cmul1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_vld (s0_vld_q),
        .conj_en(s0_q.conj),
        .ar     (s0_q.a1r),
        .ai     (s0_q.a1i),
        .sr     (s0_q.sr),
        .si     (s0_q.si),
        .out_vld(m1_vld),
        .out_re (m1_re),
        .out_im (m1_im),
        .out_sat(m1_sat)
    );

    // Entry ordering: smaller row first, last/eof only on the final entry of the beat.
    always_comb begin
        push    = m0_vld;
        two     = m1_vld & ~s1_q.merge;
        swap    = s1_q.z1 < s1_q.z0;
        eof_col = (col_q == IDX_W'(MAT_RANK - 1));
        e_first  = '0;
        e_second = '0;
        e_first.col  = CSC_IDX_W'(col_q);
        e_second.col = CSC_IDX_W'(col_q);
        if (two && swap) begin
            e_first.row  = CSC_IDX_W'(s1_q.z1);
            e_first.re   = CSC_DW'(m1_re);
            e_first.im   = CSC_DW'(m1_im);
            e_second.row = CSC_IDX_W'(s1_q.z0);
            e_second.re  = CSC_DW'(m0_re);
            e_second.im  = CSC_DW'(m0_im);
        end else begin
            e_first.row  = CSC_IDX_W'(s1_q.z0);
            e_first.re   = CSC_DW'(m0_re);
            e_first.im   = CSC_DW'(m0_im);
            e_second.row = CSC_IDX_W'(s1_q.z1);
            e_second.re  = CSC_DW'(m1_re);
            e_second.im  = CSC_DW'(m1_im);
        end
        e_first.last  = ~two;
        e_first.eof   = ~two & eof_col;
        e_second.last = 1'b1;
        e_second.eof  = eof_col;
    end

    // Output register only shows entries already stored, so a fresh write appears a cycle later.
    always_comb begin
        pop      = out_vld_q & out_rdy;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = e_first;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
            if (two) begin
                mem_d[wr_ptr_d] = e_second;
                wr_ptr_d        = ptr_inc(wr_ptr_d);
            end
        end
        rd_ptr_d  = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d   = count_q - cnt_t'(pop) + cnt_t'(push) + cnt_t'(two);
        remain    = count_q - cnt_t'(pop);
        out_vld_d = (remain != '0);
        out_ent_d = out_vld_d ? mem_q[rd_ptr_d] : '0;
        col_d     = push ? (eof_col ? '0 : col_q + IDX_W'(1)) : col_q;
        sat_d     = sat_q | (m0_vld & m0_sat) | (two & m1_sat);
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_vld_q  <= 1'b0;
            s0_q      <= '0;
            s1_q      <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            out_vld_q <= 1'b0;
            out_ent_q <= '0;
            col_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            s0_vld_q  <= s0_vld_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            out_vld_q <= out_vld_d;
            out_ent_q <= out_ent_d;
            col_q     <= col_d;
            sat_q     <= sat_d;
        end
    end

    always_comb begin
        out_vld  = out_vld_q;
        out_row  = out_ent_q.row[IDX_W-1:0];
        out_col  = out_ent_q.col[IDX_W-1:0];
        out_re   = out_ent_q.re[DW-1:0];
        out_im   = out_ent_q.im[DW-1:0];
        out_last = out_ent_q.last;
        out_eof  = out_ent_q.eof;
        sat_err  = sat_q;
    end

endmodule

// File: tb/tb_csc_col_gen.sv
// Directed bench for csc_col_gen: ordering, merge, conj, saturation,
// latency, credit backpressure, column wrap and mid-stream reset.
module tb_csc_col_gen;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_vld = 1'b0;
    logic               in_rdy;
    logic               conj_en = 1'b0;
    logic [7:0]         z0 = '0, z1 = '0;
    logic signed [31:0] s_re = '0, s_im = '0, a0_re = '0, a0_im = '0, a1_re = '0, a1_im = '0;
    logic               out_vld;
    logic               out_rdy = 1'b0;
    logic [7:0]         out_row, out_col;
    logic signed [31:0] out_re, out_im;
    logic               out_last, out_eof, sat_err;

    int checks = 0;
    int errors = 0;

    csc_col_gen #(.MAT_RANK(256), .DW(32), .SHIFT(1), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .conj_en(conj_en),
        .z0(z0), .z1(z1), .s_re(s_re), .s_im(s_im),
        .a0_re(a0_re), .a0_im(a0_im), .a1_re(a1_re), .a1_im(a1_im),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_row(out_row), .out_col(out_col),
        .out_re(out_re), .out_im(out_im), .out_last(out_last), .out_eof(out_eof),
        .sat_err(sat_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int zz0, input int zz1, input int sr, input int si,
                         input int a0r, input int a0i, input int a1r, input int a1i,
                         input bit cj);
        z0 = 8'(zz0); z1 = 8'(zz1);
        s_re = sr; s_im = si;
        a0_re = a0r; a0_im = a0i; a1_re = a1r; a1_im = a1i;
        conj_en = cj;
    endtask

    task automatic send(input int zz0, input int zz1, input int sr, input int si,
                        input int a0r, input int a0i, input int a1r, input int a1i,
                        input bit cj);
        bit ok = 1'b0;
        @(negedge clk);
        drive(zz0, zz1, sr, si, a0r, a0i, a1r, a1i, cj);
        in_vld = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (in_rdy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        #1 in_vld = 1'b0;
        chk("send_accept", 64'(ok), 1);
    endtask

    task automatic get(input string tag, input int row, input int col, input int re,
                       input int im, input bit last, input bit eof);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_vld) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_seen"}, 64'(ok), 1);
        if (ok) begin
            chk({tag, "_row"}, out_row, row);
            chk({tag, "_col"}, out_col, col);
            chk({tag, "_re"}, out_re, re);
            chk({tag, "_im"}, out_im, im);
            chk({tag, "_last"}, out_last, last);
            chk({tag, "_eof"}, out_eof, eof);
            out_rdy = 1'b1;
            @(posedge clk);
            #1 out_rdy = 1'b0;
        end
    endtask

    initial begin
        int acc;
        bit seen;

        repeat (3) @(negedge clk);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_in_rdy", in_rdy, 0);
        chk("rst_sat_err", sat_err, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_out_re", out_re, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_rdy", in_rdy, 1);

        // distinct rows ascending, with first-entry latency
        send(3, 7, 2, 0, 5, 1, -4, 2, 0);
        repeat (3) @(negedge clk);
        chk("lat_T2_vld", out_vld, 0);
        @(negedge clk);
        chk("lat_T3_vld", out_vld, 1);
        get("t1a", 3, 0, 5, 1, 0, 0);
        get("t1b", 7, 0, -4, 2, 1, 0);

        // descending rows are swapped
        send(9, 2, 2, 0, 5, 1, -4, 2, 0);
        get("t2a", 2, 1, -4, 2, 0, 0);
        get("t2b", 9, 1, 5, 1, 1, 0);

        // merge
        send(4, 4, 0, 2, 1, 1, 1, 1, 0);
        get("t3", 4, 2, -2, 2, 1, 0);

        // conjugate
        send(0, 1, 1, 1, 2, 0, 0, 2, 1);
        get("t4a", 0, 3, 1, -1, 0, 0);
        get("t4b", 1, 3, 1, 1, 1, 0);

        // saturation, sticky flag
        chk("sat_before", sat_err, 0);
        send(5, 6, 2147483647, 0, 2147483647, 0, 0, 0, 0);
        get("t5a", 5, 4, 2147483647, 0, 0, 0);
        get("t5b", 6, 4, 0, 0, 1, 0);
        chk("sat_set", sat_err, 1);

        // credit backpressure: out_rdy low, in_vld held
        acc = 0;
        @(negedge clk);
        drive(1, 2, 2, 0, 5, 1, -4, 2, 0);
        in_vld = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (in_rdy) acc++;
            @(negedge clk);
        end
        in_vld = 1'b0;
        chk("bp_accepted", acc, 4);
        chk("bp_in_rdy", in_rdy, 0);
        for (int b = 0; b < 4; b++) begin
            get("bp_lo", 1, 5 + b, 5, 1, 0, 0);
            get("bp_hi", 2, 5 + b, -4, 2, 1, 0);
        end
        chk("sat_sticky", sat_err, 1);

        // run to the end of the frame and wrap
        for (int k = 9; k < 256; k++) begin
            send(k, k, 2, 0, 5, 1, -4, 2, 0);
            get("wrap", k, k, 1, 3, 1, k == 255);
        end
        send(20, 20, 2, 0, 5, 1, -4, 2, 0);
        get("col0", 20, 0, 1, 3, 1, 0);

        // reset mid-stream
        send(11, 12, 2, 0, 5, 1, -4, 2, 0);
        send(13, 14, 2, 0, 5, 1, -4, 2, 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_vld) begin
                seen = 1'b1;
                break;
            end
        end
        chk("pre_rst_vld", 64'(seen), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_vld", out_vld, 0);
        chk("mid_rst_in_rdy", in_rdy, 0);
        chk("mid_rst_sat", sat_err, 0);
        chk("mid_rst_row", out_row, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_empty", out_vld, 0);
        send(3, 7, 2, 0, 5, 1, -4, 2, 0);
        get("rs_a", 3, 0, 5, 1, 0, 0);
        get("rs_b", 7, 0, -4, 2, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
